// File: rtl/multigate_pkg.sv
// Shared constants and state encoding for the multigate one-hot line driver.
// MULTIGATE_SCAN_EN adds the scan states.
package multigate_pkg;

  localparam int unsigned NUM_LINES = 16;
  localparam int unsigned IDX_W     = 4;

`ifdef MULTIGATE_SCAN_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_SCAN_DRIVE,
    ST_SCAN_GAP
  } dec_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } dec_state_t;
`endif

endpackage

// File: rtl/multigate_dec4to16.sv
// Combinational 4-bit index to 16-bit one-hot decoder; en low forces all-zero.
module multigate_dec4to16
  import multigate_pkg::*;
(
  input  logic                 en,
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_LINES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/multigate_dec16_seq.sv
// Sequenced 4-to-16 one-hot line driver with break-before-make gap after each word.
// Optional index scan mode enabled by defining MULTIGATE_SCAN_EN.
module multigate_dec16_seq
  import multigate_pkg::*;
#(
  parameter int unsigned HOLD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic [HOLD_W-1:0]    in_hold,
  output logic [NUM_LINES-1:0] bus,
  output logic                 busy,
  output logic                 done
`ifdef MULTIGATE_SCAN_EN
  ,
  input  logic                 scan_start
`endif
);

  dec_state_t           state, state_d;
  logic [HOLD_W-1:0]    cnt, cnt_d;
  logic [IDX_W-1:0]     idx_r, idx_d;
  logic                 en_d;
  logic                 done_d;
  logic [NUM_LINES-1:0] bus_d;
  logic                 scan_go;
  logic                 xfer;

`ifdef MULTIGATE_SCAN_EN
  logic [HOLD_W-1:0]    hold_r, hold_d;
  assign scan_go = (state == ST_IDLE) && scan_start;
`else
  assign scan_go = 1'b0;
`endif

  assign in_ready = ((state == ST_IDLE) || (state == ST_GAP)) && !scan_go;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);

  // The decoder sees next-cycle index/enable so bus is a plain register of its output.
  multigate_dec4to16 u_dec (
    .en     (en_d),
    .idx    (idx_d),
    .onehot (bus_d)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx_r;
    en_d    = 1'b0;
    done_d  = 1'b0;
`ifdef MULTIGATE_SCAN_EN
    hold_d  = hold_r;
`endif
    case (state)
      ST_IDLE, ST_GAP: begin
        if (scan_go) begin
`ifdef MULTIGATE_SCAN_EN
          state_d = ST_SCAN_DRIVE;
          idx_d   = '0;
          cnt_d   = in_hold;
          hold_d  = in_hold;
          en_d    = 1'b1;
`endif
        end else if (xfer) begin
          state_d = ST_DRIVE;
          idx_d   = in_idx;
          cnt_d   = in_hold;
          en_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt == '0) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - HOLD_W'(1);
          en_d  = 1'b1;
        end
      end
`ifdef MULTIGATE_SCAN_EN
      ST_SCAN_DRIVE: begin
        if (cnt == '0) begin
          state_d = ST_SCAN_GAP;
          done_d  = (idx_r == '1);
        end else begin
          cnt_d = cnt - HOLD_W'(1);
          en_d  = 1'b1;
        end
      end
      ST_SCAN_GAP: begin
        if (idx_r == '1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN_DRIVE;
          idx_d   = idx_r + IDX_W'(1);
          cnt_d   = hold_r;
          en_d    = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx_r  <= '0;
      bus    <= '0;
      done   <= 1'b0;
`ifdef MULTIGATE_SCAN_EN
      hold_r <= '0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx_r  <= idx_d;
      bus    <= bus_d;
      done   <= done_d;
`ifdef MULTIGATE_SCAN_EN
      hold_r <= hold_d;
`endif
    end
  end

endmodule

// File: doc/multigate_dec16_seq.md
# multigate_dec16_seq

Sequenced 4-to-16 one-hot line driver: the expanding counterpart to the team's multi-input AND/OR reduction gates. Accepts a 4-bit line index over a valid/ready handshake and drives the matching bit of a 16-bit one-hot bus for a programmable number of cycles. Every word is followed by a one-cycle all-zero gap. Downstream `multigate_or16`/`multigate_and8` style reducers can therefore sample a clean, break-before-make select bus.

## Interface
Parameters:
- `HOLD_W`, default 4: width of the hold-count field.

Ports:
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : reset, asynchronous and active-low.
- `in_valid`  in  1  : request present.
- `in_ready`  out  1  : block can accept a request this cycle.
- `in_idx`  in  4  : line to assert (0..15).
- `in_hold`  in  HOLD_W  : drive length minus one (0 means 1 cycle).
- `bus`  out  16  : one-hot or all-zero select bus, registered.
- `busy`  out  1  : high in any state other than IDLE.
- `done`  out  1  : single-cycle pulse marking end of a word (or end of a scan).
- `scan_start`  in  1  : present only with `MULTIGATE_SCAN_EN`.

## Operation
- States: IDLE, DRIVE, GAP, plus SCAN_DRIVE and SCAN_GAP with `MULTIGATE_SCAN_EN`.
- Handshake: transfer when `in_valid & in_ready` at a rising edge. `in_idx`/`in_hold` are captured at that edge; later input changes are ignored.
- `in_ready` = (state is IDLE or GAP) and not a scan start this cycle.
- IDLE → DRIVE on transfer. `bus` = 1<<idx, and the hold counter loads `in_hold`.
- DRIVE: counter decrements each cycle. When it is 0, go to GAP.
- GAP: `bus` = 0 and `done` = 1. A transfer in GAP goes to DRIVE; otherwise go to IDLE.
- `bus` never has more than one bit set, and never changes directly from one nonzero value to another.
- Out-of-range input is impossible: `in_idx` is exactly 4 bits.
- Reset (any time, including mid-DRIVE): `bus` = 0, `done` = 0, `busy` = 0, `in_ready` = 1 once released, state = IDLE, counter = 0. Reset takes effect asynchronously.

## Timing
- Transfer at edge N: `bus` is valid from cycle N+1 for `in_hold`+1 cycles. GAP follows for 1 cycle with `done` high.
- Back-to-back throughput: one word per `in_hold`+2 cycles when `in_valid` is held high.
- `busy` rises the cycle after a transfer and falls the cycle after a GAP with no new transfer.
- `in_hold` = 2^HOLD_W−1 gives the maximum drive length of 2^HOLD_W cycles. There is no wrap, and the counter saturates at 0.

## Configuration
- `MULTIGATE_SCAN_EN` defined:
  - Adds the `scan_start` port, sampled only in IDLE. It has priority over `in_valid` in the same cycle, and `in_ready` is low that cycle.
  - Latches `in_hold`, then walks indices 0..15. Each index is driven `in_hold`+1 cycles in SCAN_DRIVE, followed by a 1-cycle SCAN_GAP.
  - `done` pulses only in the gap after index 15. `in_ready` stays low throughout the scan.
  - Reset aborts the scan.
- `MULTIGATE_SCAN_EN` undefined: no `scan_start` port, no SCAN states, and the behaviour is exactly as above.

## Structure
- Package `multigate_pkg`: `NUM_LINES` = 16, `IDX_W` = 4, and the state enum `dec_state_t` (SCAN states under the macro).
- Sub-module `multigate_dec4to16`: pure combinational 4-bit index → 16-bit one-hot, with an enable input forcing all-zero. Its output is registered in the top module to form `bus`.

## Test plan
- Reset, then idle: `bus` = 0, `busy` = 0, `in_ready` = 1, `done` = 0.
- Single request: idx=5, hold=2 → `bus` = 0x0020 for 3 cycles from N+1, then 0x0000 with `done` = 1, then IDLE.
- Back-to-back: idx=0, hold=0 then idx=15, hold=0 with `in_valid` held → `bus` sequence 0x0001, 0x0000, 0x8000, 0x0000, with `done` in both gaps and no idle cycle between words.
- Reset asserted mid-DRIVE (idx=9, hold=7, at cycle 3) → `bus` goes to 0 immediately without waiting for the clock. After release, `busy` = 0 and the next request behaves normally.
- Max hold: idx=3, hold=2^HOLD_W−1 → `bus` = 0x0008 for exactly 2^HOLD_W cycles. Also check that inputs changed during DRIVE have no effect.
- With `MULTIGATE_SCAN_EN`: `scan_start` and `in_valid` asserted in the same IDLE cycle with hold=1 → the request is not accepted. `bus` walks 0x0001…0x8000, 2 cycles each with zero gaps (48 cycles total), and `done` pulses once at the end.
